// File: rtl/magnetron_sr_driver.sv
// Control stage ahead of the magnetron SR latch: synchronizes and debounces user
// inputs, runs the cooking state machine and emits non-overlapping S/R pulses.
module magnetron_sr_driver #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       S,
  output logic       R,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned N_IN  = 5;
  localparam int unsigned N_BTN = 3;
  localparam int unsigned DCW   = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int unsigned PCW   = (PULSE_W < 2) ? 1 : $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COOKING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  logic [N_IN-1:0]  sync1, sync2;
  logic [N_BTN-1:0] deb, deb_q;
  logic [DCW-1:0]   deb_cnt [N_BTN];
  logic             door_q;

  logic   start_evt, stop_evt, clear_evt;
  logic   door_s, timer_s, door_fall;
  state_t state_q, state_d;
  logic   s_req, r_req;

  logic           s_q, r_q, s_pend, mag_on_q, done_q;
  logic [PCW-1:0] pcnt;
  logic           p_last;

  // Two-flop synchronizers; bit order {timer, door, clear, stop, start}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {timer_done, door_closed, clear_btn, stop_btn, start_btn};
      sync2 <= sync1;
    end
  end

  // Debounce: level flips after DEB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb    <= '0;
      deb_q  <= '0;
      door_q <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) deb_cnt[i] <= '0;
    end else begin
      deb_q  <= deb;
      door_q <= sync2[3];
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign start_evt = deb[0] & ~deb_q[0];
  assign stop_evt  = deb[1] & ~deb_q[1];
  assign clear_evt = deb[2] & ~deb_q[2];
  assign door_s    = sync2[3];
  assign timer_s   = sync2[4];
  assign door_fall = door_q & ~door_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and pulse requests; priority door > clear > stop > timer > start
  always_comb begin
    state_d = state_q;
    s_req   = 1'b0;
    r_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_evt && door_s && !timer_s) begin
          state_d = ST_COOKING;
          s_req   = 1'b1;
        end
      end
      ST_COOKING: begin
        if (!door_s) begin
          state_d = ST_PAUSED;
          r_req   = 1'b1;
        end else if (clear_evt) begin
          state_d = ST_IDLE;
          r_req   = 1'b1;
        end else if (stop_evt) begin
          state_d = ST_PAUSED;
          r_req   = 1'b1;
        end else if (timer_s) begin
          state_d = ST_DONE;
          r_req   = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (clear_evt) begin
          state_d = ST_IDLE;
        end else if (start_evt && door_s && !timer_s) begin
          state_d = ST_COOKING;
          s_req   = 1'b1;
        end
      end
      ST_DONE: begin
        if (clear_evt || door_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign p_last = (pcnt == '0);

  // Pulse generator: R preempts S on the same edge; S waits out an active R
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      s_pend <= 1'b0;
      pcnt   <= '0;
    end else if (r_req) begin
      r_q    <= 1'b1;
      s_q    <= 1'b0;
      s_pend <= 1'b0;
      pcnt   <= PCW'(PULSE_W - 1);
    end else if (s_req && !r_q) begin
      s_q  <= 1'b1;
      pcnt <= PCW'(PULSE_W - 1);
    end else if (r_q && p_last) begin
      r_q <= 1'b0;
      if (s_pend || s_req) begin
        s_q    <= 1'b1;
        s_pend <= 1'b0;
        pcnt   <= PCW'(PULSE_W - 1);
      end
    end else begin
      if (s_req) s_pend <= 1'b1;
      if (s_q || r_q) begin
        if (p_last) s_q  <= 1'b0;
        else        pcnt <= pcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mag_on_q <= (state_d == ST_COOKING);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign S      = s_q;
  assign R      = r_q;
  assign mag_on = mag_on_q;
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_magnetron_sr_driver.sv
// Directed bench for magnetron_sr_driver: a default instance (PULSE_W=2) and a
// PULSE_W=4 instance share the same stimulus.
module tb_magnetron_sr_driver;

  logic clk, rst;
  logic start_btn, stop_btn, clear_btn, door_closed, timer_done;
  logic s1, r1, mag1, done1;
  logic s2, r2, mag2, done2;
  logic [1:0] st1, st2;

  int passed = 0;
  int total  = 0;
  int sr_viol = 0;

  magnetron_sr_driver #(.DEB_CYCLES(4), .PULSE_W(2)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .door_closed(door_closed), .timer_done(timer_done),
    .S(s1), .R(r1), .mag_on(mag1), .done(done1), .state(st1)
  );

  magnetron_sr_driver #(.DEB_CYCLES(4), .PULSE_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .door_closed(door_closed), .timer_done(timer_done),
    .S(s2), .R(r2), .mag_on(mag2), .done(done2), .state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((s1 & r1) | (s2 & r2)) sr_viol++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_btns();
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    clear_btn = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
    door_closed = 1'b1; timer_done = 1'b0;
    #1;
    total++;
    if ({s1, r1, mag1, done1, st1} !== 6'b0) $display("FAIL reset_outputs: got %b expected 000000", {s1, r1, mag1, done1, st1});
    else passed++;
    tick(2);
    #3 rst = 1'b0;
    tick(3);
    total++;
    if (st1 !== 2'b00 || s1 !== 1'b0) $display("FAIL reset_idle: got state=%b S=%b expected 00/0", st1, s1);
    else passed++;
  endtask

  task automatic test_start_timeout();
    start_btn = 1'b1;
    tick(6);
    total++;
    if (s1 !== 1'b0 || st1 !== 2'b00) $display("FAIL start_early: got S=%b state=%b expected 0/00", s1, st1);
    else passed++;
    tick(1);
    total++;
    if ({s1, r1, mag1, st1} !== 5'b10101) $display("FAIL start_edge7: got S,R,mag,state=%b expected 10101", {s1, r1, mag1, st1});
    else passed++;
    tick(1);
    total++;
    if (s1 !== 1'b1) $display("FAIL start_edge8: got S=%b expected 1", s1);
    else passed++;
    tick(1);
    total++;
    if (s1 !== 1'b0 || st1 !== 2'b01) $display("FAIL start_edge9: got S=%b state=%b expected 0/01", s1, st1);
    else passed++;
    tick(1);
    release_btns();
    timer_done = 1'b1;
    tick(2);
    total++;
    if (r1 !== 1'b0 || st1 !== 2'b01) $display("FAIL timer_early: got R=%b state=%b expected 0/01", r1, st1);
    else passed++;
    tick(1);
    total++;
    if ({s1, r1, mag1, done1, st1} !== 6'b010111) $display("FAIL timer_done: got %b expected 010111", {s1, r1, mag1, done1, st1});
    else passed++;
    tick(1);
    total++;
    if (r1 !== 1'b1) $display("FAIL timer_r2: got R=%b expected 1", r1);
    else passed++;
    tick(1);
    total++;
    if (r1 !== 1'b0 || st1 !== 2'b11) $display("FAIL timer_r_end: got R=%b state=%b expected 0/11", r1, st1);
    else passed++;
    timer_done = 1'b0;
    tick(3);
    clear_btn = 1'b1;
    tick(7);
    total++;
    if ({s1, r1, done1, st1} !== 5'b00000) $display("FAIL done_clear: got %b expected 00000", {s1, r1, done1, st1});
    else passed++;
    release_btns();
  endtask

  task automatic test_bounce();
    int s_seen = 0;
    for (int i = 0; i < 4; i++) begin
      start_btn = (i % 2 == 0);
      tick(1);
      if (s1) s_seen++;
    end
    start_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (s1) s_seen++;
    end
    total++;
    if (s_seen !== 0 || st1 !== 2'b00) $display("FAIL bounce: got S cycles=%0d state=%b expected 0/00", s_seen, st1);
    else passed++;
  endtask

  task automatic test_door_safety();
    start_btn = 1'b1;
    tick(7);
    total++;
    if (st1 !== 2'b01 || s1 !== 1'b1) $display("FAIL door_pre_start: got state=%b S=%b expected 01/1", st1, s1);
    else passed++;
    release_btns();
    door_closed = 1'b0;
    tick(2);
    total++;
    if (r1 !== 1'b0) $display("FAIL door_r_early: got R=%b expected 0", r1);
    else passed++;
    tick(1);
    total++;
    if ({r1, mag1, st1} !== 4'b1010) $display("FAIL door_open: got R,mag,state=%b expected 1010", {r1, mag1, st1});
    else passed++;
    tick(1);
    total++;
    if (r1 !== 1'b1) $display("FAIL door_r2: got R=%b expected 1", r1);
    else passed++;
    tick(1);
    total++;
    if (r1 !== 1'b0) $display("FAIL door_r_end: got R=%b expected 0", r1);
    else passed++;
    door_closed = 1'b1;
    tick(3);
    start_btn = 1'b1;
    tick(7);
    total++;
    if ({s1, mag1, st1} !== 4'b1101) $display("FAIL resume: got S,mag,state=%b expected 1101", {s1, mag1, st1});
    else passed++;
    release_btns();
  endtask

  task automatic test_simultaneous();
    int r_cycles = 0;
    clear_btn = 1'b1;
    stop_btn  = 1'b1;
    tick(7);
    total++;
    if (st1 !== 2'b00 || r1 !== 1'b1) $display("FAIL clear_wins: got state=%b R=%b expected 00/1", st1, r1);
    else passed++;
    r_cycles = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (r1) r_cycles++;
    end
    total++;
    if (r_cycles !== 2) $display("FAIL single_r: got %0d R cycles expected 2", r_cycles);
    else passed++;
    release_btns();
    door_closed = 1'b0;
    tick(3);
    start_btn = 1'b1;
    tick(7);
    total++;
    if (s1 !== 1'b0 || st1 !== 2'b00) $display("FAIL start_door_open: got S=%b state=%b expected 0/00", s1, st1);
    else passed++;
    release_btns();
    door_closed = 1'b1;
    tick(3);
  endtask

  task automatic test_overlap();
    start_btn = 1'b1;
    tick(7);
    total++;
    if (s2 !== 1'b1 || st2 !== 2'b01) $display("FAIL w4_start: got S=%b state=%b expected 1/01", s2, st2);
    else passed++;
    door_closed = 1'b0;
    tick(2);
    total++;
    if ({s2, r2, s1, r1} !== 4'b1000) $display("FAIL w4_pre_overlap: got S2,R2,S1,R1=%b expected 1000", {s2, r2, s1, r1});
    else passed++;
    tick(1);
    total++;
    if ({s2, r2, st2} !== 4'b0110) $display("FAIL w4_handover: got S2,R2,state=%b expected 0110", {s2, r2, st2});
    else passed++;
    tick(3);
    total++;
    if (r2 !== 1'b1 || r1 !== 1'b0) $display("FAIL w4_r_len: got R2=%b R1=%b expected 1/0", r2, r1);
    else passed++;
    tick(1);
    total++;
    if (r2 !== 1'b0) $display("FAIL w4_r_end: got R2=%b expected 0", r2);
    else passed++;
    start_btn = 1'b0;
    door_closed = 1'b1;
    tick(10);
    clear_btn = 1'b1;
    tick(7);
    total++;
    if (st1 !== 2'b00 || st2 !== 2'b00) $display("FAIL paused_clear: got state=%b/%b expected 00/00", st1, st2);
    else passed++;
    release_btns();
  endtask

  task automatic test_async_reset();
    start_btn = 1'b1;
    tick(7);
    release_btns();
    stop_btn = 1'b1;
    tick(7);
    total++;
    if (r1 !== 1'b1 || st1 !== 2'b10) $display("FAIL stop_r: got R=%b state=%b expected 1/10", r1, st1);
    else passed++;
    stop_btn = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if ({r1, mag1, st1, r2} !== 5'b00000) $display("FAIL async_reset: got R,mag,state,R2=%b expected 00000", {r1, mag1, st1, r2});
    else passed++;
    #1 rst = 1'b0;
    tick(3);
    start_btn = 1'b1;
    tick(7);
    total++;
    if ({s1, mag1, st1} !== 4'b1101) $display("FAIL post_reset_start: got S,mag,state=%b expected 1101", {s1, mag1, st1});
    else passed++;
    release_btns();
  endtask

  task automatic test_invariant();
    total++;
    if (sr_viol !== 0) $display("FAIL sr_invariant: got %0d overlapping cycles expected 0", sr_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_start_timeout();
    test_bounce();
    test_door_safety();
    test_simultaneous();
    test_overlap();
    test_async_reset();
    test_invariant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
